// File: rtl/lockin_ref_correlator.sv
// lockin_ref_correlator: multiplies one averaged period by stored sin/cos references and accumulates X/Y lock-in sums.
module lockin_ref_correlator #(
  parameter int M = 32,
  parameter int Q_IN = 32,
  parameter int Q_REF = 16,
  parameter int ACC_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    ref_wr_en,
  input  logic [6:0]              ref_addr,
  input  logic signed [Q_REF-1:0] ref_sin,
  input  logic signed [Q_REF-1:0] ref_cos,
  input  logic [Q_IN-1:0]         data_in,
  input  logic                    data_in_valid,
  output logic                    busy,
  output logic signed [ACC_W-1:0] x_out,
  output logic signed [ACC_W-1:0] y_out,
  output logic                    out_valid
);
  localparam int LG = $clog2(M);
  localparam int P_W = Q_IN + 1 + Q_REF;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [LG-1:0] n;
  logic signed [Q_REF-1:0] sin_tab [M];
  logic signed [Q_REF-1:0] cos_tab [M];
  logic s1_v, s2_v, take, unused_addr;
  logic signed [Q_IN:0] s1_d;
  logic signed [Q_REF-1:0] s1_sin, s1_cos;
  logic signed [P_W-1:0] p_x, p_y;
  logic signed [ACC_W-1:0] acc_x, acc_y;
  assign take = state == ACCUM && data_in_valid;
  assign busy = state != IDLE;
  assign unused_addr = ^ref_addr;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // DRAIN exits once both pipeline stages are empty, i.e. the final accumulate has landed
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (start ? ACCUM : IDLE) :
               state == ACCUM ? ((take && n == LG'(M - 1)) ? DRAIN : ACCUM) :
               state == DRAIN ? ((!s1_v && !s2_v) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk)
    if (state == IDLE && ref_wr_en) begin
      sin_tab[ref_addr[LG-1:0]] <= ref_sin;
      cos_tab[ref_addr[LG-1:0]] <= ref_cos;
    end
  always_ff @(posedge clk) begin
    if (reset) begin
      n <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      acc_x <= '0;
      acc_y <= '0;
      x_out <= '0;
      y_out <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_v <= take;
      s2_v <= s1_v;
      out_valid <= state == DONE;
      if (state == IDLE && start) begin
        n <= '0;
        acc_x <= '0;
        acc_y <= '0;
      end
      if (take) begin
        n <= n + 1'b1;
        s1_d <= {1'b0, data_in};
        s1_sin <= sin_tab[n];
        s1_cos <= cos_tab[n];
      end
      if (s1_v) begin
        p_x <= P_W'(s1_d) * P_W'(s1_sin);
        p_y <= P_W'(s1_d) * P_W'(s1_cos);
      end
      if (s2_v) begin
        acc_x <= acc_x + {{(ACC_W - P_W){p_x[P_W-1]}}, p_x};
        acc_y <= acc_y + {{(ACC_W - P_W){p_y[P_W-1]}}, p_y};
      end
      if (state == DONE) begin
        x_out <= acc_x;
        y_out <= acc_y;
      end
    end
  end
endmodule

// File: tb/tb_lockin_ref_correlator.sv
// tb_lockin_ref_correlator: directed vectors with hand-computed X/Y sums for the lock-in correlator.
module tb_lockin_ref_correlator;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, ref_wr_en = 1'b0, data_in_valid = 1'b0;
  logic [6:0] ref_addr = '0;
  logic signed [15:0] ref_sin = '0, ref_cos = '0;
  logic [31:0] data_in = '0;
  logic busy, out_valid;
  logic signed [63:0] x_out, y_out;
  int checks = 0, failures = 0, cyc = 0, ov_cnt = 0, ov_cyc = 0, last_cyc = 0, prev = 0;
  logic [63:0] ov_x, ov_y;
  logic ov_busy;

  lockin_ref_correlator dut (
    .clk(clk), .reset(reset), .start(start), .ref_wr_en(ref_wr_en), .ref_addr(ref_addr),
    .ref_sin(ref_sin), .ref_cos(ref_cos), .data_in(data_in), .data_in_valid(data_in_valid),
    .busy(busy), .x_out(x_out), .y_out(y_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (out_valid) begin
      ov_cnt++;
      ov_cyc = cyc;
      ov_x = x_out;
      ov_y = y_out;
      ov_busy = busy;
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int s, input int c);
    ref_wr_en = 1'b1;
    ref_addr = a[6:0];
    ref_sin = s[15:0];
    ref_cos = c[15:0];
    tick;
    ref_wr_en = 1'b0;
  endtask

  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    data_in = d;
    data_in_valid = 1'b1;
    tick;
    data_in_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic wait_ov(input string tag, input int p);
    for (int i = 0; i < 30 && ov_cnt == p; i++) tick;
    check(tag, 64'(ov_cnt), 64'(p + 1));
  endtask

  function automatic logic [31:0] da(input int k);
    return k < 16 ? 32'd5 : 32'd2;
  endfunction

  initial begin
    tick;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 32; k++) wr(k, k < 16 ? 1 : -1, 0);
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    check("rst_x", x_out, 64'sd0);
    check("rst_y", y_out, 64'sd0);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    prev = ov_cnt;
    go;
    check("busy_after_start", 64'(busy), 64'd1);
    for (int k = 0; k < 32; k++) send(da(k));
    wait_ov("f1_ov", prev);
    check("f1_latency", 64'(ov_cyc - last_cyc), 64'd4);
    check("f1_busy_at_ov", 64'(ov_busy), 64'd0);
    check("f1_x", ov_x, 64'sd48);
    check("f1_y", ov_y, 64'sd0);

    prev = ov_cnt;
    go;
    for (int k = 0; k < 32; k++) begin
      if (k == 20) repeat (10) tick;
      send(da(k));
      tick;
    end
    wait_ov("gap_ov", prev);
    check("gap_x", ov_x, 64'sd48);
    check("gap_y", ov_y, 64'sd0);

    go;
    for (int k = 0; k < 17; k++) send(32'd1000);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    prev = ov_cnt;
    repeat (10) tick;
    check("abort_no_ov", 64'(ov_cnt), 64'(prev));
    go;
    for (int k = 0; k < 32; k++) send(da(k));
    wait_ov("fresh_ov", prev);
    check("fresh_x", ov_x, 64'sd48);
    check("fresh_y", ov_y, 64'sd0);
    repeat (5) tick;
    check("hold_x", x_out, 64'sd48);

    prev = ov_cnt;
    go;
    for (int k = 0; k < 2; k++) send(da(k));
    ref_wr_en = 1'b1;
    ref_addr = 7'd3;
    ref_sin = 16'sd100;
    ref_cos = 16'sd100;
    start = 1'b1;
    tick;
    ref_wr_en = 1'b0;
    start = 1'b0;
    for (int k = 2; k < 40; k++) send(k < 32 ? da(k) : 32'd1000);
    wait_ov("ovr_ov", prev);
    check("ovr_x", ov_x, 64'sd48);
    check("ovr_y", ov_y, 64'sd0);
    repeat (10) tick;
    check("ovr_single_ov", 64'(ov_cnt), 64'(prev + 1));

    for (int k = 1; k < 32; k++) wr(k, -32768, -32768);
    prev = ov_cnt;
    ref_wr_en = 1'b1;
    ref_addr = 7'd0;
    ref_sin = -16'sd32768;
    ref_cos = -16'sd32768;
    start = 1'b1;
    tick;
    ref_wr_en = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 32; k++) send(32'hFFFF_FFFF);
    wait_ov("max_ov", prev);
    check("max_x", ov_x, -64'sd4503599626321920);
    check("max_y", ov_y, -64'sd4503599626321920);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lockin_ref_correlator.md
Name: lockin_ref_correlator

Overview:
Downstream consumer of the coherent averager's period buffer. It takes one averaged period (M unsigned 32-bit words, streamed with a valid strobe), multiplies each word by a stored sine and cosine reference sample, and accumulates to produce the in-phase (X) and quadrature (Y) lock-in components for that frame. The reference tables are loaded through a write port while the block is idle.

Parameters:
M, 32, samples per frame (one signal period); power of two, 2..128
Q_in, 32, input sample width (unsigned)
Q_ref, 16, reference sample width (signed two's complement)
ACC_W, 64, accumulator and output width (signed); must be >= Q_in+1+Q_ref+log2(M)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, arms a new frame
ref_wr_en  in  1  reference table write strobe
ref_addr  in  7  table index, lower log2(M) bits used
ref_sin  in  Q_ref  sine reference word
ref_cos  in  Q_ref  cosine reference word
data_in  in  Q_in  averaged sample, unsigned
data_in_valid  in  1  data_in qualifier
busy  out  1  high from accepted start until out_valid
x_out  out  ACC_W  in-phase sum, signed
y_out  out  ACC_W  quadrature sum, signed
out_valid  out  1  one-cycle pulse, x_out/y_out valid

Behaviour:
- Reset: state IDLE, n=0, accumulators=0, pipeline valids=0, busy=0, x_out=0, y_out=0, out_valid=0. Table contents are not cleared. Reset mid-frame aborts the frame with no out_valid.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - ref_wr_en writes sin/cos[ref_addr] in the same cycle.
  - start -> ACCUM; n and both accumulators cleared; busy=1.
  - data_in_valid ignored.
- ACCUM:
  - Each data_in_valid cycle accepts one sample at index n; n increments.
  - Gaps in valid stall n; the pipeline only advances valid-tagged stages.
  - Sample with n==M-1 -> DRAIN, n wraps to 0.
  - ref_wr_en and start ignored.
- Pipeline stages:
  - S1: register sample (zero-extended to Q_in+1 signed) and table words sin[n], cos[n].
  - S2: signed multiply, two products, each Q_in+1+Q_ref bits.
  - S3: sign-extend products to ACC_W and add into acc_x/acc_y.
- DRAIN: wait until the last sample's S3 accumulate completes (3 cycles after acceptance) -> DONE. data_in_valid is ignored here.
- DONE (1 cycle): x_out=acc_x, y_out=acc_y, out_valid=1, busy=0 -> IDLE.
- Latency: last sample accepted on edge t; out_valid is high during cycle t+4, i.e. registered on edge t+4.
- x_out/y_out hold their value until the next DONE or reset.
- start coincident with ref_wr_en in IDLE: both take effect, and the write lands before the first sample fetch.
- start during ACCUM, DRAIN or DONE: ignored, not queued.
- No saturation. A correctly sized ACC_W cannot overflow; undersized ACC_W wraps modulo 2^ACC_W.
- Samples beyond M in a frame are dropped.

Test Plan:
- Reset, then read outputs -> x_out=0, y_out=0, out_valid=0, busy=0; table contents persist across reset.
- M=32, sin[n]=+1 (n<16) / -1 (n>=16), cos=0, start, data=5 for n<16 and 2 for n>=16, contiguous valid -> x_out=48, y_out=0, out_valid exactly 4 edges after the last sample, busy low in that same cycle.
- Same frame with valid deasserted every other cycle plus a 10-cycle gap at n=20 -> identical x_out=48, y_out=0.
- sin=cos=-32768 all entries, data=0xFFFFFFFF all 32 -> x_out=y_out=-4503599626321920, no wrap.
- Reset asserted at n=17 mid-frame -> no out_valid, busy=0; a new start plus a full frame gives the correct result from fresh accumulators.
- ref_wr_en to addr 3 and a second start during ACCUM -> table unchanged and frame result unaffected; 40 valid samples after start -> one out_valid, samples 33-40 ignored.
